fft_frame_buffer: RTL and testbench
===================================

Name: fft_frame_buffer

Overview:
- Ping-pong frame buffer directly downstream of geralds_decimator.
- Accepts the decimated AXI-Stream (tdata/tvalid/tready/tlast) and checks that each frame is exactly FFT_SIZE samples long.
- Stores complete frames in one of two banks and replays them, gap-free and with tlast, to the FFT core, honouring FFT backpressure.
- Short frames are discarded, long frames are truncated with resynchronisation on the next tlast, and both are reported as errors.

Parameters:
- DATA_WIDTH, 32, sample width (matches the decimator tdata).
- FFT_SIZE, 1024, samples per frame; must be a power of two, >= 4.
- CNT_W, $clog2(FFT_SIZE), sample index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- s_tdata  in  DATA_WIDTH  input sample from the decimator.
- s_tvalid  in  1  input sample valid.
- s_tready  out  1  buffer can accept a sample.
- s_tlast  in  1  last sample of an input frame.
- m_tdata  out  DATA_WIDTH  sample to the FFT.
- m_tvalid  out  1  output sample valid.
- m_tready  in  1  FFT accepts the sample.
- m_tlast  out  1  last sample of an output frame.
- frame_drop  out  1  one-cycle pulse: a short frame was discarded.
- frame_trunc  out  1  one-cycle pulse: a long frame was truncated.
- frames_out  out  16  count of frames fully delivered; wraps at 65535 -> 0.

Behaviour:
- Reset (reset=0 at a clk edge):
  - both banks empty; wbank=0, rbank=0; wcnt=0, rcnt=0; write FSM = FILL.
  - s_tready=0 during reset; m_tvalid=0, m_tlast=0, m_tdata=0.
  - frame_drop=0, frame_trunc=0, frames_out=0.
  - Reset asserted mid-frame discards all stored and partial data; no partial output frame completes.
- Input accept: a sample is accepted on a cycle with s_tvalid & s_tready.
- s_tready is registered-state based:
  - FILL: s_tready = !full[wbank].
  - DROP: s_tready = 1.
- Write FSM:
  - FILL: on accept, write mem[wbank][wcnt] and advance wcnt.
    - wcnt==FFT_SIZE-1 and s_tlast=1: commit the frame. Set full[wbank]=1, toggle wbank, wcnt=0.
    - wcnt==FFT_SIZE-1 and s_tlast=0: commit the frame, pulse frame_trunc, go to DROP.
    - wcnt<FFT_SIZE-1 and s_tlast=1: discard the frame. wcnt=0, bank stays free, pulse frame_drop.
  - DROP: accepted samples are discarded. On an accepted sample with s_tlast=1, go to FILL with wcnt=0; that sample is also discarded.
- Read side:
  - m_tvalid = full[rbank]; m_tdata = mem[rbank][rcnt]; m_tlast = m_tvalid & (rcnt==FFT_SIZE-1).
  - On m_tvalid & m_tready: rcnt++.
  - At the last sample: clear full[rbank], toggle rbank, rcnt=0, frames_out++.
  - m_tdata/m_tlast hold stable while m_tvalid=1 and m_tready=0.
- Latency: the first sample of a frame appears on m_tvalid the cycle after its last input sample is accepted, provided the read bank is otherwise idle.
- Throughput: with m_tready=1 continuously, output is gap-free across frames, including back-to-back frames.
- Both banks full: s_tready=0 until a bank is freed.
- Read finishing a bank on the same cycle the write side waits on it: the freed bank's s_tready rises the next cycle. No same-cycle bypass.
- Commit and read completion on the same cycle: both take effect, since the full flags are independent per bank.
- Output frames are always exactly FFT_SIZE samples, in input order.

Test Plan (FFT_SIZE=4, DATA_WIDTH=32):
- Reset then ramp 0..7 with tlast on 3 and 7, m_tready=1 -> m_tdata 0,1,2,3,4,5,6,7; m_tlast on 3 and 7; first m_tvalid one cycle after sample 3 accepted; frames_out=2.
- m_tready=0, stream three frames -> s_tready low after the second frame commits; m_tdata holds 0. Raise m_tready -> frames 0-3, 4-7, 8-11 in order; third frame accepted after bank 0 frees.
- Frame 0,1,tlast@2 then 10,11,12,13(tlast) -> frame_drop pulses once; output only 10..13.
- Frame 0..5 with tlast@5 then 20..23(tlast) -> frame_trunc pulses at sample 3; output 0..3 then 20..23; samples 4,5 dropped.
- Random m_tready (50%) over 100 continuous frames -> scoreboard match, no stalled m_tdata change, frames_out=100.
- Assert reset after 2 samples of a frame and after one output sample -> all outputs return to reset values; the next full frame outputs cleanly with frames_out=1.

Source files
------------

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer between the decimator and the FFT core.
// Validates input frame length, stores whole frames and replays them gap-free with tlast.
module fft_frame_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int FFT_SIZE   = 1024,
  parameter int CNT_W      = $clog2(FFT_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  frame_drop,
  output logic                  frame_trunc,
  output logic [15:0]           frames_out
);

  // state | meaning
  // FILL  | writing samples of the current frame into bank wbank
  // DROP  | frame overran FFT_SIZE; discarding until its tlast
  typedef enum logic {
    FILL = 1'b0,
    DROP = 1'b1
  } wstate_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FFT_SIZE - 1);

  wstate_t               wstate;
  logic [DATA_WIDTH-1:0] mem [2*FFT_SIZE];
  logic [1:0]            full;
  logic                  wbank;
  logic                  rbank;
  logic [CNT_W-1:0]      wcnt;
  logic [CNT_W-1:0]      rcnt;
  logic                  s_acc;
  logic                  m_acc;
  logic                  wr_en;
  logic                  w_last;
  logic                  r_last;

  assign s_tready = reset & ((wstate == DROP) | ~full[wbank]);
  assign s_acc    = s_tvalid & s_tready;
  assign wr_en    = s_acc & (wstate == FILL);
  assign w_last   = (wcnt == LAST_IDX);

  assign m_tvalid = full[rbank];
  assign m_acc    = m_tvalid & m_tready;
  assign r_last   = (rcnt == LAST_IDX);
  assign m_tlast  = m_tvalid & r_last;
  assign m_tdata  = m_tvalid ? mem[{rbank, rcnt}] : '0;

  // Sample storage needs no reset: the full flags gate everything that reads it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wbank, wcnt}] <= s_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wstate      <= FILL;
      full        <= '0;
      wbank       <= 1'b0;
      rbank       <= 1'b0;
      wcnt        <= '0;
      rcnt        <= '0;
      frame_drop  <= 1'b0;
      frame_trunc <= 1'b0;
      frames_out  <= '0;
    end else begin
      frame_drop  <= 1'b0;
      frame_trunc <= 1'b0;

      case (wstate)
        FILL: begin
          if (wr_en) begin
            if (w_last) begin
              full[wbank] <= 1'b1;
              wbank       <= ~wbank;
              wcnt        <= '0;
              if (!s_tlast) begin
                frame_trunc <= 1'b1;
                wstate      <= DROP;
              end
            end else if (s_tlast) begin
              wcnt       <= '0;
              frame_drop <= 1'b1;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        DROP: begin
          if (s_acc && s_tlast) begin
            wstate <= FILL;
          end
        end
        default: wstate <= FILL;
      endcase

      // Write only targets a free bank and read only a full one, so these never collide.
      if (m_acc) begin
        if (r_last) begin
          full[rbank] <= 1'b0;
          rbank       <= ~rbank;
          rcnt        <= '0;
          frames_out  <= frames_out + 16'd1;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Self-checking bench for fft_frame_buffer with FFT_SIZE=4: frame-level model feeding
// an output scoreboard, a table of frame shapes, and hand-written reset/backpressure cases.
module tb_fft_frame_buffer;
  localparam int DW = 32;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          frame_drop;
  logic          frame_trunc;
  logic [15:0]   frames_out;

  fft_frame_buffer #(.DATA_WIDTH(DW), .FFT_SIZE(N), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .frame_drop(frame_drop), .frame_trunc(frame_trunc), .frames_out(frames_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  typedef struct {
    int len;
    int base;
    int exp_drop;
    int exp_trunc;
  } vec_t;

  int            n_checks = 0;
  int            n_pass   = 0;
  exp_t          expq[$];
  logic [DW-1:0] pend[$];
  bit            mdrop = 0;
  int            exp_frames = 0;
  int            drop_seen = 0;
  int            trunc_seen = 0;
  bit            rand_ready = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  vec_t          tbl[8];

  task automatic chk(string name, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Frame-level reference: what the FFT should see for each accepted input sample.
  function automatic void model_accept(logic [DW-1:0] d, logic last);
    if (!mdrop) begin
      pend.push_back(d);
      if (pend.size() == N) begin
        for (int i = 0; i < N; i++) expq.push_back('{pend[i], 1'(i == N - 1)});
        exp_frames++;
        if (!last) mdrop = 1;
        pend.delete();
      end else if (last) begin
        pend.delete();
      end
    end else if (last) begin
      mdrop = 0;
    end
  endfunction

  task automatic send(logic [DW-1:0] d, logic last);
    bit acc = 0;
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    for (int t = 0; t < 500 && !acc; t++) begin
      #1;
      acc = s_tready;
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (acc) model_accept(d, last);
    else chk("send_timeout", 0, 1);
  endtask

  task automatic send_frame(int base, int len);
    for (int i = 0; i < len; i++) send(DW'(base + i), i == len - 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    expq.delete();
    pend.delete();
    mdrop      = 0;
    exp_frames = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_frames_out", frames_out, 0);
    chk("rst_pulses", {frame_drop, frame_trunc}, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int t = 0; t < 400 && !done; t++) begin
      if (expq.size() == 0 && !m_tvalid) done = 1;
      else begin
        @(negedge clk);
        #2;
      end
    end
    chk("drain_done", done, 1);
    chk("frames_out", frames_out, exp_frames);
  endtask

  // Output monitor: drives random backpressure, scores transfers, checks stall stability.
  always @(negedge clk) begin
    if (rand_ready) m_tready = ($urandom_range(0, 1) == 1);
    #1;
    if (!reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", m_tvalid, 1);
        chk("stall_data", m_tdata, prev_data);
      end
      drop_seen  += int'(frame_drop);
      trunc_seen += int'(frame_trunc);
      if (m_tvalid && m_tready) begin
        if (expq.size() == 0) begin
          chk("output_unexpected", m_tdata, -1);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("m_tdata", m_tdata, e.data);
          chk("m_tlast", m_tlast, e.last);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, t0;
    reset    = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;

    tbl[0] = '{3, 0,  1, 0};
    tbl[1] = '{4, 10, 0, 0};
    tbl[2] = '{6, 0,  0, 1};
    tbl[3] = '{4, 20, 0, 0};
    tbl[4] = '{2, 30, 1, 0};
    tbl[5] = '{5, 40, 0, 1};
    tbl[6] = '{1, 50, 1, 0};
    tbl[7] = '{4, 60, 0, 0};

    // Ramp with two frames and first-output latency.
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) send(DW'(i), 1'b0);
    #1;
    chk("latency_pre", m_tvalid, 0);
    send(DW'(3), 1'b1);
    #1;
    chk("latency", m_tvalid, 1);
    for (int i = 4; i < 8; i++) send(DW'(i), i == 7);
    wait_drain();
    chk("ramp_frames", frames_out, 2);

    // Both banks full under backpressure, then release.
    do_reset();
    m_tready = 1'b0;
    fork
      for (int i = 0; i < 12; i++) send(DW'(i), (i % 4) == 3);
      begin
        repeat (14) @(negedge clk);
        #2;
        chk("full_s_tready", s_tready, 0);
        chk("full_m_tvalid", m_tvalid, 1);
        chk("full_m_tdata", m_tdata, 0);
        @(negedge clk);
        m_tready = 1'b1;
      end
    join
    wait_drain();
    chk("full_frames", frames_out, 3);

    // Table of frame shapes: short, exact and long frames.
    do_reset();
    m_tready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      d0 = drop_seen;
      t0 = trunc_seen;
      send_frame(tbl[k].base, tbl[k].len);
      repeat (2) @(negedge clk);
      #2;
      chk($sformatf("drop_%0d", k), drop_seen - d0, tbl[k].exp_drop);
      chk($sformatf("trunc_%0d", k), trunc_seen - t0, tbl[k].exp_trunc);
    end
    for (int i = 0; i < 3; i++) send(DW'(70 + i), 1'b0);
    send(DW'(73), 1'b0);
    #1;
    chk("trunc_at_3", frame_trunc, 1);
    send(DW'(74), 1'b1);
    wait_drain();

    // Random backpressure over 100 back-to-back frames.
    do_reset();
    rand_ready = 1;
    for (int f = 0; f < 100; f++) send_frame(1000 + f * N, N);
    wait_drain();
    rand_ready = 0;
    m_tready   = 1'b1;
    chk("frames_100", frames_out, 100);

    // Reset mid-input-frame, then mid-output-frame.
    do_reset();
    m_tready = 1'b1;
    send(DW'(500), 1'b0);
    send(DW'(501), 1'b0);
    do_reset();
    send_frame(600, N);
    do_reset();
    send_frame(700, N);
    wait_drain();
    chk("post_reset_frames", frames_out, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
